wave_meas: RTL and testbench

//  Measures a periodic waveform sampled from the ADC loopback of the AWG output (offset-binary codes).

---
 rtl/wave_meas_pkg.sv | 20 ++
 rtl/wave_meas_cross.sv | 52 +++++
 rtl/wave_meas.sv | 183 ++++++++++++++++++
 tb/tb_wave_meas.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/wave_meas_pkg.sv
// wave_meas_pkg: shared types and default constants for the waveform meter.
package wave_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ARM,
    ST_SYNC,
    ST_MEAS
  } state_e;

  localparam int DW_DEF   = 14;
  localparam int PW_DEF   = 24;
  localparam int MID_DEF  = 8192;
  localparam int HYST_DEF = 64;

  // Number of waveform cycles folded into one result in the averaging build.
  localparam int AVG_N     = 4;
  localparam int AVG_SHIFT = 2;

endpackage

// File: rtl/wave_meas_cross.sv
// wave_meas_cross: Schmitt-trigger flag with rising-crossing detect.
// The flag sets at MID+HYST, clears at MID-HYST, and only moves on strobed samples.
module wave_meas_cross #(
  parameter int DW   = 14,
  parameter int MID  = 8192,
  parameter int HYST = 64
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          clr_i,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] sample_i,
  output logic          hi_o,
  output logic          rise_o
);

  localparam logic [DW-1:0] RISE_LVL = DW'(MID + HYST);
  localparam logic [DW-1:0] FALL_LVL = DW'(MID - HYST);

  logic hi_q, hi_d;
  logic aboveRise, belowFall;

  assign aboveRise = (sample_i >= RISE_LVL);
  assign belowFall = (sample_i <= FALL_LVL);

  // Next flag value; set wins over clear so HYST=0 still yields a clean edge.
  always_comb begin
    hi_d = hi_q;
    if (clr_i) begin
      hi_d = 1'b0;
    end else if (sample_valid_i) begin
      if (aboveRise) begin
        hi_d = 1'b1;
      end else if (belowFall) begin
        hi_d = 1'b0;
      end
    end
  end

  // Flag register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hi_q <= 1'b0;
    end else begin
      hi_q <= hi_d;
    end
  end

  assign hi_o   = hi_q;
  assign rise_o = hi_d & ~hi_q;

endmodule

// File: rtl/wave_meas.sv
// wave_meas: measures period, min/max and peak-to-peak of a periodic ADC waveform.
// Build option WAVE_MEAS_AVG_EN: each result covers AVG_N consecutive cycles
// (period averaged, extremes taken over the group).
module wave_meas
  import wave_meas_pkg::*;
#(
  parameter int DW   = DW_DEF,
  parameter int PW   = PW_DEF,
  parameter int MID  = MID_DEF,
  parameter int HYST = HYST_DEF
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          en_i,
  input  logic          sample_valid_i,
  input  logic [DW-1:0] sample_i,
  output logic          meas_valid_o,
  output logic [PW-1:0] period_o,
  output logic [DW-1:0] amp_max_o,
  output logic [DW-1:0] amp_min_o,
  output logic [DW-1:0] p2p_o,
  output logic          timeout_o
);

  localparam logic [PW-1:0] CNT_MAX  = '1;
  localparam logic [DW-1:0] FALL_LVL = DW'(MID - HYST);

  state_e        state_q;
  logic [PW-1:0] count_q;
  logic [DW-1:0] min_q, max_q;

  logic          hi, rise, clr;
  logic [PW-1:0] count_d, periodRep;
  logic          satHit;
  logic [DW-1:0] min_d, max_d;

  // The flag is held low outside SYNC/MEAS so the first edge seen is a real one.
  assign clr = hi && ((state_q == ST_IDLE) || (state_q == ST_ARM));

  wave_meas_cross #(
    .DW  (DW),
    .MID (MID),
    .HYST(HYST)
  ) u_cross (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .clr_i         (clr),
    .sample_valid_i(sample_valid_i),
    .sample_i      (sample_i),
    .hi_o          (hi),
    .rise_o        (rise)
  );

  // Saturating count, running extremes including the current sample, and the
  // period to report (forced to the ceiling when this sample saturates).
  always_comb begin
    count_d   = (count_q == CNT_MAX) ? count_q : count_q + PW'(1);
    satHit    = (count_d == CNT_MAX);
    min_d     = (sample_i < min_q) ? sample_i : min_q;
    max_d     = (sample_i > max_q) ? sample_i : max_q;
    periodRep = satHit ? CNT_MAX : count_q;
  end

`ifdef WAVE_MEAS_AVG_EN
  localparam int GW = $clog2(AVG_N);

  logic [GW-1:0] grp_q;
  logic [PW+1:0] sum_q, sum_d;
  logic [DW-1:0] gmin_q, gmax_q, gmin_d, gmax_d;

  // Group accumulators including the cycle that closes on this crossing.
  always_comb begin
    sum_d  = sum_q + {2'b00, periodRep};
    gmin_d = min_d;
    gmax_d = max_d;
    if (grp_q != '0) begin
      if (gmin_q < min_d) gmin_d = gmin_q;
      if (gmax_q > max_d) gmax_d = gmax_q;
    end
  end
`endif

  // Measurement FSM with registered results; en low always returns to IDLE.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      min_q        <= '0;
      max_q        <= '0;
      meas_valid_o <= 1'b0;
      period_o     <= '0;
      amp_max_o    <= '0;
      amp_min_o    <= '0;
      p2p_o        <= '0;
      timeout_o    <= 1'b0;
`ifdef WAVE_MEAS_AVG_EN
      grp_q        <= '0;
      sum_q        <= '0;
      gmin_q       <= '0;
      gmax_q       <= '0;
`endif
    end else begin
      meas_valid_o <= 1'b0;
      if (!en_i) begin
        state_q   <= ST_IDLE;
        timeout_o <= 1'b0;
`ifdef WAVE_MEAS_AVG_EN
        grp_q     <= '0;
        sum_q     <= '0;
`endif
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q <= ST_ARM;
`ifdef WAVE_MEAS_AVG_EN
            grp_q   <= '0;
            sum_q   <= '0;
`endif
          end
          ST_ARM: begin
`ifdef WAVE_MEAS_AVG_EN
            grp_q <= '0;
            sum_q <= '0;
`endif
            if (sample_valid_i && (sample_i <= FALL_LVL)) begin
              state_q <= ST_SYNC;
            end
          end
          ST_SYNC: begin
            if (rise) begin
              state_q <= ST_MEAS;
              count_q <= PW'(1);
              min_q   <= sample_i;
              max_q   <= sample_i;
            end
          end
          ST_MEAS: begin
            if (rise) begin
              count_q <= PW'(1);
              min_q   <= sample_i;
              max_q   <= sample_i;
`ifdef WAVE_MEAS_AVG_EN
              if (grp_q == GW'(AVG_N - 1)) begin
                meas_valid_o <= 1'b1;
                period_o     <= PW'(sum_d >> AVG_SHIFT);
                amp_min_o    <= gmin_d;
                amp_max_o    <= gmax_d;
                p2p_o        <= gmax_d - gmin_d;
                timeout_o    <= 1'b0;
                grp_q        <= '0;
                sum_q        <= '0;
              end else begin
                grp_q  <= grp_q + GW'(1);
                sum_q  <= sum_d;
                gmin_q <= gmin_d;
                gmax_q <= gmax_d;
              end
`else
              meas_valid_o <= 1'b1;
              period_o     <= periodRep;
              amp_min_o    <= min_d;
              amp_max_o    <= max_d;
              p2p_o        <= max_d - min_d;
              timeout_o    <= 1'b0;
`endif
            end else if (sample_valid_i) begin
              count_q <= count_d;
              if (satHit) begin
                timeout_o <= 1'b1;
                state_q   <= ST_ARM;
              end else begin
                min_q <= min_d;
                max_q <= max_d;
              end
            end
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_wave_meas.sv
// tb_wave_meas: directed checks of wave_meas.
// dutA uses the default parameters; dutB uses PW=8, MID=12288 for the
// saturation and strobed-triangle sequences.
module tb_wave_meas;
  import wave_meas_pkg::*;

  typedef struct {
    logic        en;
    logic        sv;
    logic [13:0] smp;
    logic        expValid;
    logic [23:0] expPeriod;
    logic [13:0] expMin;
    logic [13:0] expMax;
    logic [13:0] expP2p;
    logic        expTimeout;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        enA = 1'b0, svA = 1'b0;
  logic [13:0] smpA = '0;
  logic        validA, timeoutA;
  logic [23:0] periodA;
  logic [13:0] maxA, minA, p2pA;

  logic        enB = 1'b0, svB = 1'b0;
  logic [13:0] smpB = '0;
  logic        validB, timeoutB;
  logic [7:0]  periodB;
  logic [13:0] maxB, minB, p2pB;

  int checks = 0;
  int errors = 0;

  wave_meas dutA (
    .clk_i(clk), .rst_i(rst), .en_i(enA), .sample_valid_i(svA), .sample_i(smpA),
    .meas_valid_o(validA), .period_o(periodA), .amp_max_o(maxA), .amp_min_o(minA),
    .p2p_o(p2pA), .timeout_o(timeoutA)
  );

  wave_meas #(.DW(14), .PW(8), .MID(12288), .HYST(64)) dutB (
    .clk_i(clk), .rst_i(rst), .en_i(enB), .sample_valid_i(svB), .sample_i(smpB),
    .meas_valid_o(validB), .period_o(periodB), .amp_max_o(maxB), .amp_min_o(minB),
    .p2p_o(p2pB), .timeout_o(timeoutB)
  );

  // Free-running system clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d expected=%0d", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic en, input logic sv, input logic [13:0] smp);
    enA = en; svA = sv; smpA = smp;
    @(posedge clk); #1;
  endtask

  task automatic applyStimulusB(input logic en, input logic sv, input logic [13:0] smp);
    enB = en; svB = sv; smpB = smp;
    @(posedge clk); #1;
  endtask

  task automatic doReset();
    enA = 1'b0; svA = 1'b0; smpA = '0;
    enB = 1'b0; svB = 1'b0; smpB = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic logic [13:0] triSample(input int k);
    if (k < 64) return 14'(8192 + 128 * k);
    else        return 14'(16383 - 128 * (k - 64));
  endfunction

  initial begin
    vec_t vecs[13];
    int   pulses;
    logic expV;
    logic [13:0] smp;

    vecs[0]  = '{1'b1, 1'b0, 14'd0,     1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[1]  = '{1'b1, 1'b1, 14'd8128,  1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[2]  = '{1'b1, 1'b1, 14'd8256,  1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[3]  = '{1'b1, 1'b0, 14'd16000, 1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[4]  = '{1'b1, 1'b1, 14'd8200,  1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[5]  = '{1'b1, 1'b1, 14'd8128,  1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[6]  = '{1'b1, 1'b1, 14'd8255,  1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[7]  = '{1'b1, 1'b0, 14'd0,     1'b0, 24'd0, 14'd0,    14'd0,    14'd0,    1'b0};
    vecs[8]  = '{1'b1, 1'b1, 14'd8256,  1'b1, 24'd4, 14'd8128, 14'd8256, 14'd128,  1'b0};
    vecs[9]  = '{1'b1, 1'b1, 14'd9000,  1'b0, 24'd4, 14'd8128, 14'd8256, 14'd128,  1'b0};
    vecs[10] = '{1'b1, 1'b1, 14'd100,   1'b0, 24'd4, 14'd8128, 14'd8256, 14'd128,  1'b0};
    vecs[11] = '{1'b1, 1'b1, 14'd9000,  1'b1, 24'd3, 14'd100,  14'd9000, 14'd8900, 1'b0};
    vecs[12] = '{1'b0, 1'b1, 14'd5000,  1'b0, 24'd3, 14'd100,  14'd9000, 14'd8900, 1'b0};

    // Reset state of both instances.
    @(posedge clk); #1;
    checkOutput("rst_valid", 32'(validA), 0);
    checkOutput("rst_period", periodA, 0);
    checkOutput("rst_min", 32'(minA), 0);
    checkOutput("rst_max", 32'(maxA), 0);
    checkOutput("rst_p2p", 32'(p2pA), 0);
    checkOutput("rst_timeout", 32'(timeoutA), 0);
    checkOutput("rst_state", 32'(dutA.state_q), 32'(ST_IDLE));
    checkOutput("rst_periodB", 32'(periodB), 0);
    rst = 1'b0;

    // Hysteresis boundaries, ignored strobes and short periods.
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].en, vecs[i].sv, vecs[i].smp);
      checkOutput($sformatf("vec%0d_valid", i), 32'(validA), 32'(vecs[i].expValid));
      checkOutput($sformatf("vec%0d_period", i), periodA, 32'(vecs[i].expPeriod));
      checkOutput($sformatf("vec%0d_min", i), 32'(minA), 32'(vecs[i].expMin));
      checkOutput($sformatf("vec%0d_max", i), 32'(maxA), 32'(vecs[i].expMax));
      checkOutput($sformatf("vec%0d_p2p", i), 32'(p2pA), 32'(vecs[i].expP2p));
      checkOutput($sformatf("vec%0d_timeout", i), 32'(timeoutA), 32'(vecs[i].expTimeout));
    end
    checkOutput("vec_state_idle", 32'(dutA.state_q), 32'(ST_IDLE));

    // Square wave 1000/15000, 50 samples each; en dropped for i=560..569.
    doReset();
    pulses = 0;
    for (int i = 0; i < 900; i++) begin
      smp  = ((i % 100) < 50) ? 14'd1000 : 14'd15000;
      expV = (i >= 150) && (((i - 50) % 100) == 0) && (i != 650);
      applyStimulus(!(i >= 560 && i < 570), 1'b1, smp);
      checkOutput($sformatf("sq%0d_valid", i), 32'(validA), 32'(expV));
      if (validA) pulses++;
      if (expV) begin
        checkOutput("sq_period", periodA, 100);
        checkOutput("sq_min", 32'(minA), 1000);
        checkOutput("sq_max", 32'(maxA), 15000);
        checkOutput("sq_p2p", 32'(p2pA), 14000);
      end
      if (i >= 560 && i < 570) begin
        checkOutput("sq_hold_period", periodA, 100);
        checkOutput("sq_hold_p2p", 32'(p2pA), 14000);
      end
    end
    checkOutput("sq_pulses", pulses, 7);
    checkOutput("sq_state_meas", 32'(dutA.state_q), 32'(ST_MEAS));

    // Asynchronous reset in the middle of MEAS clears outputs before any edge.
    rst = 1'b1;
    #2;
    checkOutput("arst_period", periodA, 0);
    checkOutput("arst_min", 32'(minA), 0);
    checkOutput("arst_max", 32'(maxA), 0);
    checkOutput("arst_p2p", 32'(p2pA), 0);
    checkOutput("arst_state", 32'(dutA.state_q), 32'(ST_IDLE));
    @(posedge clk); #1;
    rst = 1'b0;

    // Noise within the hysteresis band never produces a crossing.
    applyStimulus(1'b1, 1'b0, 14'd0);
    applyStimulus(1'b1, 1'b1, 14'd8000);
    pulses = 0;
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'b1, 1'b1, 14'($urandom_range(8232, 8152)));
      if (validA) pulses++;
    end
    checkOutput("noise_pulses", pulses, 0);
    checkOutput("noise_state_sync", 32'(dutA.state_q), 32'(ST_SYNC));

    // Saturation with PW=8: 254 low samples after sync trip the timeout.
    doReset();
    applyStimulusB(1'b1, 1'b0, 14'd0);
    applyStimulusB(1'b1, 1'b1, 14'd10000);
    applyStimulusB(1'b1, 1'b1, 14'd13000);
    pulses = 0;
    for (int i = 0; i < 253; i++) begin
      applyStimulusB(1'b1, 1'b1, 14'd10000);
      if (validB) pulses++;
    end
    checkOutput("sat253_timeout", 32'(timeoutB), 0);
    checkOutput("sat253_state", 32'(dutB.state_q), 32'(ST_MEAS));
    applyStimulusB(1'b1, 1'b1, 14'd10000);
    checkOutput("sat254_timeout", 32'(timeoutB), 1);
    checkOutput("sat254_state", 32'(dutB.state_q), 32'(ST_ARM));
    checkOutput("sat_pulses", pulses + 32'(validB), 0);

    // Timeout stays set through re-sync, then clears on the next result.
    applyStimulusB(1'b1, 1'b1, 14'd10000);
    applyStimulusB(1'b1, 1'b1, 14'd13000);
    checkOutput("resync_timeout", 32'(timeoutB), 1);
    for (int i = 0; i < 9; i++) applyStimulusB(1'b1, 1'b1, 14'd10000);
    applyStimulusB(1'b1, 1'b1, 14'd13000);
    checkOutput("p10_valid", 32'(validB), 1);
    checkOutput("p10_period", 32'(periodB), 10);
    checkOutput("p10_min", 32'(minB), 10000);
    checkOutput("p10_max", 32'(maxB), 13000);
    checkOutput("p10_p2p", 32'(p2pB), 3000);
    checkOutput("p10_timeout", 32'(timeoutB), 0);

    // Crossing on the saturating sample: crossing wins, period reads 255.
    for (int i = 0; i < 253; i++) applyStimulusB(1'b1, 1'b1, 14'd10000);
    checkOutput("satx_pre_timeout", 32'(timeoutB), 0);
    applyStimulusB(1'b1, 1'b1, 14'd13000);
    checkOutput("satx_valid", 32'(validB), 1);
    checkOutput("satx_period", 32'(periodB), 255);
    checkOutput("satx_timeout", 32'(timeoutB), 0);
    checkOutput("satx_state", 32'(dutB.state_q), 32'(ST_MEAS));

    // Triangle 8192..16383 around MID=12288, strobed every 3rd cycle, 128 samples/cycle.
    doReset();
    applyStimulusB(1'b1, 1'b0, 14'd0);
    pulses = 0;
    for (int n = 0; n <= 300; n++) begin
      expV = (n == 161) || (n == 289);
      applyStimulusB(1'b1, 1'b1, triSample(n % 128));
      checkOutput($sformatf("tri%0d_valid", n), 32'(validB), 32'(expV));
      if (validB) pulses++;
      if (expV) begin
        checkOutput("tri_period", 32'(periodB), 128);
        checkOutput("tri_min", 32'(minB), 8192);
        checkOutput("tri_max", 32'(maxB), 16383);
        checkOutput("tri_p2p", 32'(p2pB), 8191);
      end
      for (int g = 0; g < 2; g++) begin
        applyStimulusB(1'b1, 1'b0, 14'd0);
        if (validB) pulses++;
      end
    end
    checkOutput("tri_pulses", pulses, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
